// File: rtl/sha256_stream.sv
// sha256_stream: byte-stream SHA-256 hasher with internal padding, length append
// and multi-block chaining. One message in flight; digest, tag and length are
// presented with a single-cycle ovalid pulse.
module sha256_stream (
   input  logic         clk,
   input  logic         rst,
   input  logic         tvalid,
   output logic         tready,
   input  logic         tlast,
   input  logic [31:0]  tid,
   input  logic [7:0]   tdata,
   output logic         ovalid,
   output logic [31:0]  oid,
   output logic [60:0]  olen,
   output logic [255:0] osha
);

   typedef enum logic [2:0] {ACCEPT, PAD, ROUND, UPDATE, DONE} state_t;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   state_t      state, state_nxt;
   logic [31:0] w     [16];   // block buffer; becomes the schedule window during ROUND
   logic [31:0] pad_w [16];
   logic [31:0] hh    [8];    // chaining value H0..H7
   logic [31:0] v     [8];    // working variables a..h
   logic [31:0] hsum  [8];
   logic [6:0]  pos;          // bytes held in the current block, 0..64
   logic [5:0]  rnd;
   logic [60:0] len;
   logic [63:0] bitlen;
   logic [31:0] tid_l;
   logic        started;      // first byte of the message already taken
   logic        padding;      // tlast seen; remaining passes are padding passes
   logic        marker;       // 0x80 terminator already placed
   logic        last_blk;     // block being compressed carries the length
   logic        final_now;
   logic [31:0] t1, t2, wnew;

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ACCEPT;
      else      state <= state_nxt;
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt = state;
      tready    = 1'b0;
      ovalid    = 1'b0;
      case (state)
         ACCEPT: begin
            tready = 1'b1;
            if (tvalid) begin
               if (tlast)              state_nxt = PAD;
               else if (pos == 7'd63)  state_nxt = ROUND;
            end
         end
         PAD:    state_nxt = ROUND;
         ROUND:  if (rnd == 6'd63) state_nxt = UPDATE;
         UPDATE: state_nxt = last_blk ? DONE : (padding ? PAD : ACCEPT);
         DONE: begin
            ovalid    = 1'b1;
            state_nxt = ACCEPT;
         end
         default: state_nxt = ACCEPT;
      endcase
   end

   // Padded block: keep data bytes, 0x80 at the first free byte (once), zeros
   // after it, and the bit length in words 14-15 when it fits in this block.
   always_comb begin
      bitlen    = {len, 3'b000};
      final_now = marker || (pos <= 7'd55);
      pad_w     = w;
      for (int unsigned i = 0; i < 16; i++) begin
         for (int unsigned l = 0; l < 4; l++) begin
            if (marker || (7'(i * 4 + l) > pos))
               pad_w[i][8 * (3 - l) +: 8] = 8'h00;
            else if (7'(i * 4 + l) == pos)
               pad_w[i][8 * (3 - l) +: 8] = 8'h80;
         end
      end
      if (final_now) begin
         pad_w[14] = bitlen[63:32];
         pad_w[15] = bitlen[31:0];
      end
   end

   // Round function, next schedule word and chaining sums.
   always_comb begin
      t1   = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rnd] + w[0];
      t2   = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      wnew = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
      for (int unsigned i = 0; i < 8; i++) hsum[i] = hh[i] + v[i];
   end

   // Datapath: byte packing, padding, compression, chaining and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
         for (int unsigned i = 0; i < 8; i++) begin
            hh[i] <= IV[i];
            v[i]  <= '0;
         end
         pos      <= '0;
         rnd      <= '0;
         len      <= '0;
         tid_l    <= '0;
         started  <= 1'b0;
         padding  <= 1'b0;
         marker   <= 1'b0;
         last_blk <= 1'b0;
         oid      <= '0;
         olen     <= '0;
         osha     <= '0;
      end else begin
         case (state)
            ACCEPT: begin
               if (tvalid) begin
                  case (pos[1:0])
                     2'd0:    w[pos[5:2]][31:24] <= tdata;
                     2'd1:    w[pos[5:2]][23:16] <= tdata;
                     2'd2:    w[pos[5:2]][15:8]  <= tdata;
                     default: w[pos[5:2]][7:0]   <= tdata;
                  endcase
                  pos <= pos + 7'd1;
                  len <= len + 61'd1;
                  if (!started) begin
                     tid_l   <= tid;
                     started <= 1'b1;
                  end
                  if (tlast) padding <= 1'b1;
                  if (state_nxt == ROUND)
                     for (int unsigned i = 0; i < 8; i++) v[i] <= hh[i];
               end
            end
            PAD: begin
               for (int unsigned i = 0; i < 16; i++) w[i] <= pad_w[i];
               if (pos != 7'd64) marker <= 1'b1;
               last_blk <= final_now;
               for (int unsigned i = 0; i < 8; i++) v[i] <= hh[i];
            end
            ROUND: begin
               v[0] <= t1 + t2;
               v[1] <= v[0];
               v[2] <= v[1];
               v[3] <= v[2];
               v[4] <= v[3] + t1;
               v[5] <= v[4];
               v[6] <= v[5];
               v[7] <= v[6];
               // w[0..15] always holds W[t..t+15]; shifting covers rounds 0-15 too.
               for (int unsigned i = 0; i < 15; i++) w[i] <= w[i + 1];
               w[15] <= wnew;
               rnd   <= rnd + 6'd1;
            end
            UPDATE: begin
               for (int unsigned i = 0; i < 8; i++) hh[i] <= hsum[i];
               pos <= '0;
               if (last_blk) begin
                  osha <= {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6], hsum[7]};
                  oid  <= tid_l;
                  olen <= len;
               end
            end
            DONE: begin
               for (int unsigned i = 0; i < 8; i++) hh[i] <= IV[i];
               len      <= '0;
               started  <= 1'b0;
               padding  <= 1'b0;
               marker   <= 1'b0;
               last_blk <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_stream.sv
// tb_sha256_stream: directed and gap-randomised messages against a software
// SHA-256 model; result queue plus tready-low run-length expectations.
module tb_sha256_stream;

   logic         clk = 1'b0;
   logic         rst;
   logic         tvalid;
   logic         tready;
   logic         tlast;
   logic [31:0]  tid;
   logic [7:0]   tdata;
   logic         ovalid;
   logic [31:0]  oid;
   logic [60:0]  olen;
   logic [255:0] osha;

   localparam logic [255:0] ABC_SHA = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] S56_SHA = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] HT [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef struct {
      logic [31:0]  id;
      logic [60:0]  len;
      logic [255:0] sha;
   } res_t;

   res_t        expq [$];
   int unsigned lowq [$];
   logic [7:0]  m    [$];
   int          tests = 0;
   int          fails = 0;

   sha256_stream dut (
      .clk    (clk),
      .rst    (rst),
      .tvalid (tvalid),
      .tready (tready),
      .tlast  (tlast),
      .tid    (tid),
      .tdata  (tdata),
      .ovalid (ovalid),
      .oid    (oid),
      .olen   (olen),
      .osha   (osha)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Textbook SHA-256: full padding in software, 64-word expanded schedule.
   function automatic logic [255:0] sha_ref(input logic [7:0] msg [$]);
      logic [7:0]  p [$];
      logic [31:0] hv [8];
      logic [31:0] wv [64];
      logic [31:0] a, b, c, d, e, f, g, h, x1, x2, s0, s1;
      logic [63:0] bits;
      int          base;
      p    = msg;
      bits = 64'(msg.size()) * 64'd8;
      p.push_back(8'h80);
      while ((p.size() % 64) != 56) p.push_back(8'h00);
      for (int k = 7; k >= 0; k--) p.push_back(bits[8 * k +: 8]);
      for (int i = 0; i < 8; i++) hv[i] = HT[i];
      for (int blk = 0; blk < p.size() / 64; blk++) begin
         base = blk * 64;
         for (int t = 0; t < 16; t++)
            wv[t] = {p[base + 4 * t], p[base + 4 * t + 1], p[base + 4 * t + 2], p[base + 4 * t + 3]};
         for (int t = 16; t < 64; t++) begin
            s0 = rotr(wv[t - 15], 7) ^ rotr(wv[t - 15], 18) ^ (wv[t - 15] >> 3);
            s1 = rotr(wv[t - 2], 17) ^ rotr(wv[t - 2], 19) ^ (wv[t - 2] >> 10);
            wv[t] = s1 + wv[t - 7] + s0 + wv[t - 16];
         end
         a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
         e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
         for (int t = 0; t < 64; t++) begin
            x1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + wv[t];
            x2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + x1;
            d = c; c = b; b = a; a = x1 + x2;
         end
         hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
         hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
      end
      return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic abort(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out", name);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask

   task automatic load_str(input string s);
      m.delete();
      for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
   endtask

   // Drive one message; complete=0 sends the bytes without tlast and expects no result.
   task automatic send_msg(input logic [7:0] msg [$], input logic [31:0] id,
                           input int unsigned idle, input bit complete);
      res_t        r;
      int unsigned n;
      int unsigned nb;
      if (complete) begin
         r.id  = id;
         r.len = 61'(msg.size());
         r.sha = sha_ref(msg);
         expq.push_back(r);
      end
      for (int i = 0; i < msg.size(); i++) begin
         while (idle != 0 && $urandom_range(99, 0) < idle) begin
            tvalid = 1'b0;
            tdata  = 8'($urandom);
            tlast  = 1'($urandom);
            tid    = $urandom;
            @(posedge clk); #1;
         end
         tvalid = 1'b1;
         tdata  = msg[i];
         tlast  = complete && (i == msg.size() - 1);
         tid    = (i == 0) ? id : $urandom;
         n = 0;
         @(negedge clk);
         while (!tready && n < 1000) begin
            n++;
            @(negedge clk);
         end
         if (!tready) abort("tready_wait");
         nb = 32'(i % 64) + 1;
         if (tlast) lowq.push_back(((nb <= 55) ? 1 : 2) * 66 + 1);
         else if (nb == 64) lowq.push_back(65);
         @(posedge clk); #1;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (expq.size() != 0 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (expq.size() != 0) abort("result_wait");
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   // Compare process: results in order, pulse width, and tready-low run lengths.
   int unsigned run = 0;
   logic        prev_ov = 1'b0;
   always @(negedge clk) begin
      res_t r;
      if (!rst) begin
         run     = 0;
         prev_ov = 1'b0;
      end else begin
         if (prev_ov) chk("ovalid_width", 256'(ovalid), 256'd0);
         if (ovalid) begin
            if (expq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_ovalid: actual oid %0d, required no result", oid);
            end else begin
               r = expq.pop_front();
               chk("oid", 256'(oid), 256'(r.id));
               chk("olen", 256'(olen), 256'(r.len));
               chk("osha", osha, r.sha);
            end
         end
         prev_ov = ovalid;
         if (!tready) run++;
         else if (run != 0) begin
            if (lowq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tready_low: actual %0d cycles low, required none", run);
            end else chk("tready_low", 256'(run), 256'(lowq.pop_front()));
            run = 0;
         end
      end
   end

   initial begin
      int unsigned lens  [5] = '{55, 64, 119, 128, 1000};
      int unsigned rlens [7] = '{5, 56, 64, 70, 120, 128, 200};
      rst    = 1'b0;
      tvalid = 1'b0;
      tlast  = 1'b0;
      tid    = '0;
      tdata  = '0;
      repeat (2) @(negedge clk);
      chk("rst_tready", 256'(tready), 256'd1);
      chk("rst_ovalid", 256'(ovalid), 256'd0);
      chk("rst_oid", 256'(oid), 256'd0);
      chk("rst_olen", 256'(olen), 256'd0);
      chk("rst_osha", osha, 256'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      load_str("abc");
      chk("model_abc", sha_ref(m), ABC_SHA);
      send_msg(m, 32'd111, 0, 1'b1);
      drain();
      chk("abc_osha", osha, ABC_SHA);
      chk("abc_oid", 256'(oid), 256'd111);
      chk("abc_olen", 256'(olen), 256'd3);

      load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
      chk("model_56", sha_ref(m), S56_SHA);
      send_msg(m, 32'd222, 0, 1'b1);
      drain();
      chk("s56_osha", osha, S56_SHA);
      chk("s56_olen", 256'(olen), 256'd56);

      for (int k = 0; k < 5; k++) begin
         m.delete();
         for (int i = 0; i < int'(lens[k]); i++) m.push_back(8'(i));
         send_msg(m, 32'(1000 + k), 0, 1'b1);
      end
      drain();

      for (int k = 0; k < 7; k++) begin
         m.delete();
         for (int i = 0; i < int'(rlens[k]); i++) m.push_back(8'($urandom));
         send_msg(m, 32'(111 * (k + 1)), 80, 1'b1);
      end
      drain();

      m.delete();
      for (int i = 0; i < 30; i++) m.push_back(8'(i + 7));
      send_msg(m, 32'hdead, 0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_tready", 256'(tready), 256'd1);
      chk("mid_rst_ovalid", 256'(ovalid), 256'd0);
      chk("mid_rst_oid", 256'(oid), 256'd0);
      chk("mid_rst_olen", 256'(olen), 256'd0);
      chk("mid_rst_osha", osha, 256'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (100) @(posedge clk);
      #1;

      load_str("abc");
      send_msg(m, 32'd333, 0, 1'b1);
      drain();
      chk("post_rst_osha", osha, ABC_SHA);
      chk("post_rst_oid", 256'(oid), 256'd333);
      chk("post_rst_olen", 256'(olen), 256'd3);
      chk("lowq_empty", 256'(lowq.size()), 256'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
